instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: imem read port, decode valid/ready handshake and execute-stage redirect.
// master = fetch unit; slave = the memory/decode/execute side.
interface instr_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, fetch_count,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, fetch_count,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch with one outstanding imem read and a single held word; REQ->HOLD on ack, >=2 cycles/instr.
// Decode backpressure parks the word in HOLD (no new request); a redirect flushes the held word or in-flight read.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} stateT;

  stateT       stateQ, stateD;
  logic [15:0] pcQ, pcD;
  logic [15:0] addrQ, addrD;
  logic [15:0] instrQ, instrD;
  logic [15:0] instrPcQ, instrPcD;
  logic [15:0] countQ, countD;
  logic        isJmp;
  logic [15:0] seqPc;

  assign isJmp = (bus.imem_rdata[15:13] == 3'b111);
  assign seqPc = addrQ + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ      <= RESET_PC;
      addrQ    <= 16'h0000;
      instrQ   <= 16'h0000;
      instrPcQ <= 16'h0000;
      countQ   <= 16'h0000;
    end else begin
      pcQ      <= pcD;
      addrQ    <= addrD;
      instrQ   <= instrD;
      instrPcQ <= instrPcD;
      countQ   <= countD;
    end
  end

  // The request address is captured whenever REQ is entered, so it is the pc value in force at that edge.
  always_comb begin
    stateD   = stateQ;
    pcD      = pcQ;
    addrD    = addrQ;
    instrD   = instrQ;
    instrPcD = instrPcQ;
    countD   = countQ;
    unique case (stateQ)
      IDLE: begin
        if (bus.redirect_valid) begin
          pcD = bus.redirect_pc;
        end
        addrD  = pcD;
        stateD = REQ;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pcD    = bus.redirect_pc;
          stateD = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          instrD   = bus.imem_rdata;
          instrPcD = addrQ;
          pcD      = isJmp ? {3'b000, bus.imem_rdata[12:0]} : seqPc;
          stateD   = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pcD    = bus.redirect_pc;
          addrD  = bus.redirect_pc;
          stateD = REQ;
        end else if (bus.instr_ready) begin
          countD = countQ + 16'd1;
          addrD  = pcQ;
          stateD = REQ;
        end
      end
      DROP: begin
        if (bus.redirect_valid) begin
          pcD = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign bus.imem_req    = (stateQ == REQ) || (stateQ == DROP);
  assign bus.imem_addr   = addrQ;
  assign bus.instr_valid = (stateQ == HOLD);
  assign bus.instr       = instrQ;
  assign bus.opcode      = instrQ[15:13];
  assign bus.instr_pc    = instrPcQ;
  assign bus.fetch_count = countQ;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, decode/execute stimulus, and a stream-level model of the
// expected delivered instruction sequence (next pc from last delivered word or latest redirect).
module tb_instr_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rstW;
  instr_fetch_if ifc ();
  instr_fetch_if ifcW ();

  instr_fetch #(.RESET_PC(16'h0000)) dut     (.clk(clk), .rst(rst),  .bus(ifc));
  instr_fetch #(.RESET_PC(16'hFFFF)) dutWrap (.clk(clk), .rst(rstW), .bus(ifcW));

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] mem [0:65535];

  // stream model
  logic [15:0] expNext;
  logic [15:0] cnt;
  logic [15:0] seenPc [$];
  logic [2:0]  seenOp [$];
  bit          hsFlag;

  // memory responder
  int reqAge, reqLat, fixedLat;
  bit randLat;

  // previous-cycle observations
  bit          prevReq, prevAck, prevHeld;
  logic [15:0] prevAddr, heldInstr, heldPc;

  // wrap-instance bookkeeping
  int          wGot;
  logic [15:0] wPc [0:1];
  logic [15:0] c0, i0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sampleEdge();
    @(negedge clk);
    checkVal("fetch_count", ifc.fetch_count, cnt);
    if (prevReq && !prevAck) begin
      checkVal("req_held", {15'b0, ifc.imem_req}, 16'd1);
      checkVal("addr_stable", ifc.imem_addr, prevAddr);
    end else if (ifc.imem_req) begin
      checkVal("req_addr", ifc.imem_addr, expNext);
    end
    if (prevHeld) begin
      checkVal("hold_valid", {15'b0, ifc.instr_valid}, 16'd1);
      checkVal("hold_instr", ifc.instr, heldInstr);
      checkVal("hold_pc", ifc.instr_pc, heldPc);
    end
    if (ifc.instr_valid) checkVal("no_req_in_hold", {15'b0, ifc.imem_req}, 16'd0);
  endtask

  task automatic applyIn(input bit r, input bit rd, input logic [15:0] rpc);
    bit ack;
    logic [15:0] w;
    ack = 1'b0;
    if (ifc.imem_req) begin
      if (reqAge == 0) reqLat = randLat ? int'($urandom_range(0, 3)) : fixedLat;
      ack    = (reqAge >= reqLat);
      reqAge = ack ? 0 : reqAge + 1;
    end else begin
      reqAge = 0;
    end
    ifc.imem_ack       = ack;
    ifc.imem_rdata     = ack ? mem[ifc.imem_addr] : 16'($urandom);
    ifc.instr_ready    = r;
    ifc.redirect_valid = rd;
    ifc.redirect_pc    = rd ? rpc : 16'($urandom);
    hsFlag    = 1'b0;
    prevHeld  = ifc.instr_valid && !rd && !r;
    heldInstr = ifc.instr;
    heldPc    = ifc.instr_pc;
    if (rd) begin
      expNext = rpc;
    end else if (ifc.instr_valid && r) begin
      w = mem[expNext];
      checkVal("hs_pc", ifc.instr_pc, expNext);
      checkVal("hs_instr", ifc.instr, w);
      checkVal("hs_opcode", {13'b0, ifc.opcode}, {13'b0, w[15:13]});
      seenPc.push_back(ifc.instr_pc);
      seenOp.push_back(ifc.opcode);
      expNext = (w[15:13] == 3'b111) ? {3'b000, w[12:0]} : expNext + 16'd1;
      cnt++;
      hsFlag = 1'b1;
    end
    prevReq  = ifc.imem_req;
    prevAck  = ack;
    prevAddr = ifc.imem_addr;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    ifc.imem_ack = 1'b0; ifc.imem_rdata = 16'h0; ifc.instr_ready = 1'b0;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 16'h0;
    cnt = 16'h0; expNext = 16'h0000;
    prevReq = 1'b0; prevAck = 1'b0; prevHeld = 1'b0; reqAge = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_req"},   {15'b0, ifc.imem_req}, 16'd0);
    checkVal({tag, "_valid"}, {15'b0, ifc.instr_valid}, 16'd0);
    checkVal({tag, "_instr"}, ifc.instr, 16'd0);
    checkVal({tag, "_op"},    {13'b0, ifc.opcode}, 16'd0);
    checkVal({tag, "_ipc"},   ifc.instr_pc, 16'd0);
    checkVal({tag, "_addr"},  ifc.imem_addr, 16'd0);
    checkVal({tag, "_count"}, ifc.fetch_count, 16'd0);
  endtask

  task automatic runToHs(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sampleEdge();
      applyIn(1'b1, 1'b0, 16'h0);
      if (hsFlag) begin
        ok = 1'b1;
        break;
      end
    end
    checkVal({tag, "_hs_seen"}, {15'b0, ok}, 16'd1);
  endtask

  // Returns sampled in the wanted state with that cycle's inputs not yet applied.
  task automatic waitFor(input bit wantHold, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sampleEdge();
      if (wantHold ? ifc.instr_valid : ifc.imem_req) begin
        ok = 1'b1;
        break;
      end
      applyIn(!wantHold, 1'b0, 16'h0);
    end
    checkVal({tag, "_reached"}, {15'b0, ok}, 16'd1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    rst = 1'b1; rstW = 1'b1;
    ifcW.imem_ack = 1'b0; ifcW.imem_rdata = 16'h0; ifcW.instr_ready = 1'b1;
    ifcW.redirect_valid = 1'b0; ifcW.redirect_pc = 16'h0;
    randLat = 1'b0; fixedLat = 0;

    // sequential fetch then JMP at word 5
    for (int a = 0; a < 5; a++) mem[a] = {3'b000, 13'($urandom)};
    mem[5] = 16'hE123;
    doReset(3);
    checkResetState("rst0");
    seenPc.delete(); seenOp.delete();
    for (int k = 0; k < 4; k++) runToHs("seq");
    sampleEdge();
    checkVal("seq_count4", ifc.fetch_count, 16'd4);
    applyIn(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) checkVal("seq_pc", seenPc[k], 16'(k));
    runToHs("seq"); runToHs("jmp"); runToHs("jmp_tgt");
    checkVal("jmp_pc", seenPc[5], 16'h0005);
    checkVal("jmp_op", {13'b0, seenOp[5]}, 16'h0007);
    checkVal("jmp_target", seenPc[6], 16'h0123);

    // backpressure in HOLD
    waitFor(1'b1, "bp");
    c0 = ifc.fetch_count; i0 = ifc.instr;
    for (int k = 0; k < 5; k++) begin
      applyIn(1'b0, 1'b0, 16'h0);
      sampleEdge();
      checkVal("bp_req", {15'b0, ifc.imem_req}, 16'd0);
      checkVal("bp_instr", ifc.instr, i0);
      checkVal("bp_count", ifc.fetch_count, c0);
    end
    applyIn(1'b1, 1'b0, 16'h0);

    // redirect during a slow read: old data dropped
    fixedLat = 3;
    waitFor(1'b0, "drop");
    applyIn(1'b1, 1'b1, 16'h0040);
    runToHs("drop");
    checkVal("drop_pc", seenPc[$], 16'h0040);
    // two redirects while draining: the later one wins
    waitFor(1'b0, "drop2");
    applyIn(1'b1, 1'b1, 16'h0040);
    sampleEdge();
    applyIn(1'b1, 1'b1, 16'h0050);
    runToHs("drop2");
    checkVal("drop2_pc", seenPc[$], 16'h0050);

    // redirect and ready together in HOLD
    fixedLat = 0;
    waitFor(1'b1, "rr");
    c0 = ifc.fetch_count;
    applyIn(1'b1, 1'b1, 16'h0010);
    sampleEdge();
    checkVal("rr_count", ifc.fetch_count, c0);
    applyIn(1'b1, 1'b0, 16'h0);
    runToHs("rr");
    checkVal("rr_pc", seenPc[$], 16'h0010);

    // ack+redirect in REQ gives an idle gap; redirect in IDLE retargets
    waitFor(1'b0, "idle");
    applyIn(1'b1, 1'b1, 16'h0200);
    sampleEdge();
    checkVal("idle_gap", {15'b0, ifc.imem_req}, 16'd0);
    applyIn(1'b1, 1'b1, 16'h0300);
    runToHs("idle");
    checkVal("idle_pc", seenPc[$], 16'h0300);

    // randomized traffic
    randLat = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      sampleEdge();
      applyIn(($urandom % 10) < 7, ($urandom % 12) == 0, 16'($urandom));
    end

    // reset in the middle of a request, then a stray ack
    randLat = 1'b0; fixedLat = 3;
    runToHs("pre_rst");
    sampleEdge();
    checkVal("pre_rst_req", {15'b0, ifc.imem_req}, 16'd1);
    doReset(1);
    checkResetState("rst_mid");
    ifc.imem_ack = 1'b1; ifc.imem_rdata = 16'hE0FF;
    runToHs("post_rst");
    checkVal("post_rst_pc", seenPc[$], 16'h0000);

    // RESET_PC = FFFF wraps to 0000
    repeat (2) @(negedge clk);
    rstW = 1'b0;
    wGot = 0;
    for (int i = 0; i < 40 && wGot < 2; i++) begin
      @(negedge clk);
      if (ifcW.instr_valid) begin
        wPc[wGot] = ifcW.instr_pc;
        wGot++;
      end
      ifcW.imem_ack   = ifcW.imem_req;
      ifcW.imem_rdata = 16'h1234;
    end
    checkVal("wrap_got", 16'(wGot), 16'd2);
    checkVal("wrap_pc0", wPc[0], 16'hFFFF);
    checkVal("wrap_pc1", wPc[1], 16'h0000);
    @(negedge clk);
    checkVal("wrap_count", ifcW.fetch_count, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
